// File: rtl/matriz_pkg.sv
// matriz_pkg: shared 5x7 matrix geometry and scan FSM state encoding.
// Used by the attack manager, the map builder and the LED matrix scanner.
package matriz_pkg;
    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 7;
    typedef enum logic [1:0] {OFF, BLANK, DRIVE} estado_t;
endpackage

// File: rtl/varredura_matriz_leds_if.sv
// varredura_matriz_leds_if: bundle between the attack manager and the LED scanner.
// Ports: enable, matriz0..4 (column words), coordColuna/coordLinha (cursor) flow
// master->slave; colunas (active-low one-cold), linhas (rows), frame_tick flow back.
interface varredura_matriz_leds_if;
    logic       enable;
    logic [6:0] matriz0, matriz1, matriz2, matriz3, matriz4;
    logic [2:0] coordColuna, coordLinha;
    logic [4:0] colunas;
    logic [6:0] linhas;
    logic       frame_tick;
    modport master (
        output enable, matriz0, matriz1, matriz2, matriz3, matriz4, coordColuna, coordLinha,
        input  colunas, linhas, frame_tick
    );
    modport slave (
        input  enable, matriz0, matriz1, matriz2, matriz3, matriz4, coordColuna, coordLinha,
        output colunas, linhas, frame_tick
    );
endinterface

// File: rtl/contador_modulo.sv
// contador_modulo: modulo-N counter with count enable, sync clear and terminal-count pulse.
// Ports: clock, reset (async, active-high), en, clr, cnt (current value),
// tc (high in the cycle the counter is enabled at N-1 and wraps to 0).
module contador_modulo #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;
    assign tc  = en && !clr && cnt_q == W'(N - 1);
    assign cnt = cnt_q;
    always_comb cnt_d = clr ? '0 : !en ? cnt_q : tc ? '0 : cnt_q + W'(1);
    always_ff @(posedge clock or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
endmodule

// File: rtl/varredura_matriz_leds.sv
// varredura_matriz_leds: time-multiplexed 5x7 LED matrix column scan with blanking
// gap, per-frame snapshot of the image and a blinking cursor overlay.
// Ports: clock, reset (async, active-high), bus (slave side of varredura_matriz_leds_if):
// enable, matriz0..4, coordColuna, coordLinha in; colunas, linhas, frame_tick out (registered).
module varredura_matriz_leds
    import matriz_pkg::*;
#(
    parameter int DIV_SCAN     = 5000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 50
) (
    input logic                    clock,
    input logic                    reset,
    varredura_matriz_leds_if.slave bus
);
    localparam int SW = $clog2(DIV_SCAN);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    estado_t state_q, state_d;
    logic [SW-1:0] slot;
    logic [2:0] col;
    logic [FW-1:0] frame;
    logic slot_tc, col_tc, run, load;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0] snap_q, snap_d;
    logic [2:0] cc_q, cc_d, cl_q, cl_d;
    logic blink_q, blink_d;
    logic [NUM_ROWS-1:0] hit, pix;
    logic [NUM_COLS-1:0] colunas_q, colunas_d;
    logic [NUM_ROWS-1:0] linhas_q, linhas_d;
    logic frame_tick_q, frame_tick_d;

    // Counters run only while scanning with enable held; any pause restarts from column 0.
    assign run = state_q != OFF && bus.enable;

    contador_modulo #(.N(DIV_SCAN), .W(SW)) u_slot (
        .clock(clock), .reset(reset), .en(run), .clr(!run), .cnt(slot), .tc(slot_tc)
    );
    contador_modulo #(.N(NUM_COLS), .W(3)) u_col (
        .clock(clock), .reset(reset), .en(slot_tc), .clr(!run), .cnt(col), .tc(col_tc)
    );
    contador_modulo #(.N(BLINK_FRAMES), .W(FW)) u_frame (
        .clock(clock), .reset(reset), .en(col_tc), .clr(!run), .cnt(frame), .tc()
    );

    always_comb begin
        state_d = !bus.enable ? OFF :
                  state_q == OFF ? BLANK :
                  (state_q == BLANK && slot == SW'(BLANK_CYC - 1)) ? DRIVE :
                  slot_tc ? BLANK : state_q;
        // Snapshot on scan start and on frame wrap only, so mid-frame updates never tear.
        load    = bus.enable && (state_q == OFF || col_tc);
        snap_d  = load ? {bus.matriz4, bus.matriz3, bus.matriz2, bus.matriz1, bus.matriz0} : snap_q;
        cc_d    = load ? bus.coordColuna : cc_q;
        cl_d    = load ? bus.coordLinha : cl_q;
        blink_d = !run ? 1'b0 : (col_tc && frame == FW'(BLINK_FRAMES - 1)) ? ~blink_q : blink_q;
        // Out-of-range coordinates give no overlay rather than aliasing onto another pixel.
        hit     = (cc_q < 3'(NUM_COLS) && cl_q < 3'(NUM_ROWS) && cc_q == col) ? 7'd1 << cl_q : '0;
        pix     = snap_q[col] ^ (hit & {NUM_ROWS{blink_q}});
        colunas_d    = state_q == DRIVE ? ~(5'd1 << col) : '1;
        linhas_d     = state_q == DRIVE ? pix : '0;
        frame_tick_d = col_tc;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q      <= OFF;
            snap_q       <= '0;
            cc_q         <= '0;
            cl_q         <= '0;
            blink_q      <= 1'b0;
            colunas_q    <= '1;
            linhas_q     <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            cc_q         <= cc_d;
            cl_q         <= cl_d;
            blink_q      <= blink_d;
            colunas_q    <= colunas_d;
            linhas_q     <= linhas_d;
            frame_tick_q <= frame_tick_d;
        end

    assign bus.colunas    = colunas_q;
    assign bus.linhas     = linhas_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_varredura_matriz_leds.sv
// tb_varredura_matriz_leds: randomized and directed bench for the LED matrix scanner
// against a time-index reference model (slot/column/frame derived from cycles since start).
module tb_varredura_matriz_leds;
    localparam int D  = 4;
    localparam int B  = 1;
    localparam int BF = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    varredura_matriz_leds_if bus();
    varredura_matriz_leds #(.DIV_SCAN(D), .BLANK_CYC(B), .BLINK_FRAMES(BF)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    bit         m_on;
    int         m_t;
    logic [6:0] m_buf [5];
    logic [2:0] m_cc, m_cl;
    logic [4:0] e_col;
    logic [6:0] e_lin;
    logic       e_ft;

    task automatic capture();
        m_buf[0] = bus.matriz0;
        m_buf[1] = bus.matriz1;
        m_buf[2] = bus.matriz2;
        m_buf[3] = bus.matriz3;
        m_buf[4] = bus.matriz4;
        m_cc = bus.coordColuna;
        m_cl = bus.coordLinha;
    endtask

    task automatic model_reset();
        m_on = 0;
        m_t = 0;
        for (int i = 0; i < 5; i++) m_buf[i] = '0;
        m_cc = '0;
        m_cl = '0;
        e_col = 5'h1F;
        e_lin = '0;
        e_ft = 1'b0;
    endtask

    // Registered outputs follow the pre-edge scan position; then advance the scan position.
    task automatic step();
        int slot, col, bl;
        logic [6:0] px;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_on) begin
            slot = m_t % D;
            col  = (m_t / D) % 5;
            bl   = (m_t / (5 * D) / BF) % 2;
            px   = m_buf[col];
            if (bl == 1 && m_cc < 5 && m_cl < 7 && int'(m_cc) == col) px = px ^ (7'd1 << m_cl);
            e_col = slot >= B ? ~(5'd1 << col) : 5'h1F;
            e_lin = slot >= B ? px : 7'd0;
            e_ft  = bus.enable && slot == D - 1 && col == 4;
        end else begin
            e_col = 5'h1F;
            e_lin = '0;
            e_ft  = 1'b0;
        end
        if (!bus.enable) m_on = 0;
        else if (!m_on) begin
            m_on = 1;
            m_t = 0;
            capture();
        end else begin
            m_t++;
            if (m_t % (5 * D) == 0) capture();
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        step();
        #1;
        chk({tag, ".colunas"}, 32'(bus.colunas), 32'(e_col));
        chk({tag, ".linhas"}, 32'(bus.linhas), 32'(e_lin));
        chk({tag, ".frame_tick"}, 32'(bus.frame_tick), 32'(e_ft));
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, ".colunas"}, 32'(bus.colunas), 32'h1F);
        chk({tag, ".linhas"}, 32'(bus.linhas), 32'h0);
        chk({tag, ".frame_tick"}, 32'(bus.frame_tick), 32'h0);
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1 chk_dark(tag);
        tick(tag);
        #2 reset = 1'b0;
    endtask

    // Continuous invariants on the physical outputs.
    int         blank_run = 0;
    logic [4:0] last_col = 5'h1F;
    always @(negedge clock) begin
        if (reset) begin
            blank_run = 0;
            last_col = 5'h1F;
        end else begin
            chk("inv.onecold", 32'($countones(~bus.colunas) <= 1), 32'd1);
            if (bus.colunas == 5'h1F) begin
                chk("inv.dark_linhas", 32'(bus.linhas), 32'd0);
                blank_run++;
            end else begin
                if (bus.colunas != last_col) chk("inv.blank_gap", 32'(blank_run >= B), 32'd1);
                blank_run = 0;
                last_col = bus.colunas;
            end
        end
    end

    initial begin
        int last, n;
        bit found;
        bus.enable = 1'b0;
        bus.matriz0 = '0; bus.matriz1 = '0; bus.matriz2 = '0; bus.matriz3 = '0; bus.matriz4 = '0;
        bus.coordColuna = '0;
        bus.coordLinha = '0;
        #1 reset = 1'b1;
        model_reset();
        #1 chk_dark("rst");
        repeat (2) tick("rst");
        #2 reset = 1'b0;

        bus.matriz0 = 7'b1110001;
        bus.coordColuna = 3'd7;
        bus.coordLinha = 3'd7;
        bus.enable = 1'b1;
        last = -1;
        n = 0;
        repeat (65) begin
            tick("p1");
            n++;
            if (bus.frame_tick) begin
                if (last >= 0) chk("p1.ft_period", 32'(n - last), 32'd20);
                last = n;
            end
        end

        bus.enable = 1'b0;
        repeat (2) tick("p2off");
        bus.matriz0 = '0;
        bus.coordColuna = 3'd1;
        bus.coordLinha = 3'd5;
        bus.enable = 1'b1;
        repeat (122) tick("p2");

        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_on && (m_t / D) % 5 == 2 && m_t % D >= B) found = 1;
            else tick("p3w");
        end
        chk("p3.found_col2", 32'(found), 32'd1);
        bus.matriz4 = 7'b1110000;
        repeat (45) tick("p3");

        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_on && (m_t / D) % 5 == 3 && m_t % D >= B) found = 1;
            else tick("p4w");
        end
        chk("p4.found_col3", 32'(found), 32'd1);
        bus.enable = 1'b0;
        tick("p4");
        tick("p4");
        chk_dark("p4.dark");
        repeat (3) tick("p4off");
        bus.enable = 1'b1;
        repeat (25) tick("p4r");

        tick("p5");
        bus.enable = 1'b0;
        async_reset("p5");
        repeat (3) tick("p5off");
        bus.enable = 1'b1;
        repeat (30) tick("p5r");

        repeat (700) begin
            tick("rnd");
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0: bus.matriz0 = 7'($urandom);
                    1: bus.matriz1 = 7'($urandom);
                    2: bus.matriz2 = 7'($urandom);
                    3: bus.matriz3 = 7'($urandom);
                    default: bus.matriz4 = 7'($urandom);
                endcase
            end
            if ($urandom_range(0, 15) == 0) begin
                bus.coordColuna = 3'($urandom_range(0, 5));
                bus.coordLinha = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
